// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: instruction constants and the IF/ID bundle.
package fetch_stage_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INC = 32'd4;

  // IF/ID register contents, also consumed by decode_stage.
  typedef struct packed {
    logic [INSTR_W-1:0] instruction;
    logic [31:0]        pc_plus4;
    logic               valid;
  } if_id_t;

  // Per-edge action of the fetch stage, in priority order.
  typedef enum logic [1:0] {
    OpLoad,
    OpRedirect,
    OpStall,
    OpFetch
  } fetch_op_e;

  localparam if_id_t IF_ID_FLUSH = '{instruction: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones. Updates on the falling clock edge.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // Increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register, falling-edge like the rest of the pipeline.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID register, fetch/bubble counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               SYS_clk,
  input  logic               SYS_reset_n,
  input  logic               SYS_load,
  input  logic [7:0]         SYS_pc_val,
  input  logic               D_stall,
  input  logic               EX_redirect,
  input  logic [31:0]        EX_target,
  output logic [31:0]        IMEM_PC,
  input  logic [INSTR_W-1:0] IMEM_instruction,
  output logic [INSTR_W-1:0] F_instruction,
  output logic [31:0]        F_pc_plus4,
  output logic               F_valid,
  output logic [CNT_W-1:0]   F_fetch_count,
  output logic [CNT_W-1:0]   F_bubble_count
);

  logic [31:0] pc_q, pc_d;
  if_id_t      if_id_q, if_id_d;
  fetch_op_e   op;
  logic        fetch_inc, bubble_inc;
  logic        unused_addr_lsbs;

  // Address low bits are discarded by word alignment.
  assign unused_addr_lsbs = ^{SYS_pc_val[1:0], EX_target[1:0]};

  // Resolve control priority: load > redirect > stall > fetch.
  always_comb begin
    op = OpFetch;
    if (SYS_load) begin
      op = OpLoad;
    end else if (EX_redirect) begin
      op = OpRedirect;
    end else if (D_stall) begin
      op = OpStall;
    end
  end

  // Next PC, next IF/ID and counter enables.
  always_comb begin
    pc_d       = pc_q;
    if_id_d    = if_id_q;
    fetch_inc  = 1'b0;
    bubble_inc = 1'b0;
    unique case (op)
      OpLoad: begin
        pc_d       = word_align({24'h0, SYS_pc_val});
        if_id_d    = IF_ID_FLUSH;
        bubble_inc = 1'b1;
      end
      OpRedirect: begin
        pc_d       = word_align(EX_target);
        if_id_d    = IF_ID_FLUSH;
        bubble_inc = 1'b1;
      end
      OpStall: begin
        bubble_inc = 1'b1;
      end
      OpFetch: begin
        pc_d                = pc_q + PC_INC;
        if_id_d.instruction = IMEM_instruction;
        if_id_d.pc_plus4    = pc_q + PC_INC;
        if_id_d.valid       = 1'b1;
        fetch_inc           = 1'b1;
      end
      default: ;
    endcase
  end

  // PC and IF/ID registers, updated on the falling edge.
  always_ff @(negedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      pc_q    <= RESET_PC;
      if_id_q <= IF_ID_FLUSH;
    end else begin
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_fetch_cnt (
    .clk_i   (SYS_clk),
    .rst_ni  (SYS_reset_n),
    .inc_i   (fetch_inc),
    .count_o (F_fetch_count)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk_i   (SYS_clk),
    .rst_ni  (SYS_reset_n),
    .inc_i   (bubble_inc),
    .count_o (F_bubble_count)
  );

  assign IMEM_PC       = pc_q;
  assign F_instruction = if_id_q.instruction;
  assign F_pc_plus4    = if_id_q.pc_plus4;
  assign F_valid       = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus random bench for fetch_stage against a behavioural model.
module tb_fetch_stage;

  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             load;
  logic [7:0]       pc_val;
  logic             stall;
  logic             redirect;
  logic [31:0]      target;
  logic [31:0]      imem_pc;
  logic [31:0]      imem_data;
  logic [31:0]      f_instr;
  logic [31:0]      f_pc4;
  logic             f_valid;
  logic [CNT_W-1:0] f_fetch;
  logic [CNT_W-1:0] f_bubble;

  int total = 0;
  int bad   = 0;

  // Model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int          m_fetch, m_bubble;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (CNT_W)
  ) dut (
    .SYS_clk          (clk),
    .SYS_reset_n      (rst_n),
    .SYS_load         (load),
    .SYS_pc_val       (pc_val),
    .D_stall          (stall),
    .EX_redirect      (redirect),
    .EX_target        (target),
    .IMEM_PC          (imem_pc),
    .IMEM_instruction (imem_data),
    .F_instruction    (f_instr),
    .F_pc_plus4       (f_pc4),
    .F_valid          (f_valid),
    .F_fetch_count    (f_fetch),
    .F_bubble_count   (f_bubble)
  );

  // Instruction memory: word i holds 32'h1000_0000 + i.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  assign imem_data = imem_word(imem_pc);

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".pc"},     imem_pc, m_pc);
    check({ctx, ".instr"},  f_instr, m_instr);
    check({ctx, ".pc4"},    f_pc4, m_pc4);
    check({ctx, ".valid"},  {31'b0, f_valid}, {31'b0, m_valid});
    check({ctx, ".fetch"},  {{(32-CNT_W){1'b0}}, f_fetch}, 32'(m_fetch));
    check({ctx, ".bubble"}, {{(32-CNT_W){1'b0}}, f_bubble}, 32'(m_bubble));
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    m_fetch = 0; m_bubble = 0;
  endtask

  // One falling edge: apply the priority rules to the model, then compare.
  task automatic step(input logic l, input logic [7:0] pv, input logic r,
                      input logic [31:0] t, input logic s, input string ctx);
    load = l; pc_val = pv; redirect = r; target = t; stall = s;
    @(negedge clk);
    if (l) begin
      m_pc = {24'h0, pv[7:2], 2'b00};
      m_instr = 0; m_pc4 = 0; m_valid = 0;
      m_bubble = (m_bubble + 1 > CNT_MAX) ? CNT_MAX : m_bubble + 1;
    end else if (r) begin
      m_pc = {t[31:2], 2'b00};
      m_instr = 0; m_pc4 = 0; m_valid = 0;
      m_bubble = (m_bubble + 1 > CNT_MAX) ? CNT_MAX : m_bubble + 1;
    end else if (s) begin
      m_bubble = (m_bubble + 1 > CNT_MAX) ? CNT_MAX : m_bubble + 1;
    end else begin
      m_instr = imem_word(m_pc);
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      m_fetch = (m_fetch + 1 > CNT_MAX) ? CNT_MAX : m_fetch + 1;
    end
    #1;
    check_all(ctx);
  endtask

  initial begin
    load = 0; pc_val = 0; stall = 0; redirect = 0; target = 0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    #1 rst_n = 1'b1;

    // Free-run from reset
    step(0, 8'h0, 0, 32'h0, 0, "run0");
    check("run0.instr_abs", f_instr, 32'h1000_0000);
    step(0, 8'h0, 0, 32'h0, 0, "run1");
    step(0, 8'h0, 0, 32'h0, 0, "run2");
    check("run2.pc4_abs", f_pc4, 32'd12);
    check("run2.pc_abs", imem_pc, 32'd12);

    // Stall holds PC and IF/ID
    step(0, 8'h0, 0, 32'h0, 1, "stall0");
    step(0, 8'h0, 0, 32'h0, 1, "stall1");
    check("stall1.bubble_abs", {28'h0, f_bubble}, 32'd2);
    step(0, 8'h0, 0, 32'h0, 0, "after_stall");
    check("after_stall.instr_abs", f_instr, 32'h1000_0003);

    // Redirect beats stall
    step(0, 8'h0, 1, 32'h0000_0043, 1, "redir");
    check("redir.pc_abs", imem_pc, 32'h40);
    step(0, 8'h0, 0, 32'h0, 0, "redir_next");
    check("redir_next.instr_abs", f_instr, 32'h1000_0010);

    // Load beats redirect, then held load
    step(1, 8'h27, 1, 32'h0000_1000, 0, "load");
    check("load.pc_abs", imem_pc, 32'h24);
    step(1, 8'h27, 0, 32'h0, 0, "load_hold0");
    step(1, 8'h27, 0, 32'h0, 1, "load_hold1");

    // PC wrap
    step(0, 8'h0, 1, 32'hFFFF_FFFC, 0, "wrap_redir");
    step(0, 8'h0, 0, 32'h0, 0, "wrap0");
    check("wrap0.pc4_abs", f_pc4, 32'h0);
    step(0, 8'h0, 0, 32'h0, 0, "wrap1");
    check("wrap1.pc_abs", imem_pc, 32'h4);

    // Fetch counter saturation
    for (int i = 0; i < 20; i++) step(0, 8'h0, 0, 32'h0, 0, "sat");
    check("sat.fetch_abs", {28'h0, f_fetch}, 32'hF);

    // Random control mix
    for (int i = 0; i < 300; i++) begin
      int unsigned roll;
      roll = $urandom_range(0, 99);
      step(roll < 5, 8'($urandom), (roll >= 5) && (roll < 15), $urandom,
           $urandom_range(0, 3) == 0, "rand");
    end

    // Asynchronous reset between edges, mid-stall
    stall = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    #1 rst_n = 1'b1;
    step(0, 8'h0, 0, 32'h0, 0, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of `decode_stage`. Owns the PC register and the IF/ID pipeline register. Handles external PC load, stalls from the hazard unit and branch/jump redirects from EX, and keeps saturating fetch/bubble counters for LED debug output. Drives the combinational `IMEM` read port and presents a registered instruction, PC+4 and valid bit to decode.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset; must be word-aligned.
- `CNT_W`, default 16: width of the fetch and bubble counters.

- `SYS_clk`  in  1  pipeline clock; all state updates on the falling edge, like the other stages.
- `SYS_reset_n`  in  1  asynchronous, active-low reset.
- `SYS_load`  in  1  load the PC from `SYS_pc_val`.
- `SYS_pc_val`  in  8  byte address to load; bits [1:0] are ignored.
- `D_stall`  in  1  hazard-unit stall: hold the PC and IF/ID.
- `EX_redirect`  in  1  taken branch or jump resolved in EX.
- `EX_target`  in  32  redirect byte address; bits [1:0] are ignored.
- `IMEM_PC`  out  32  current PC to `IMEM`; equal to the PC register.
- `IMEM_instruction`  in  32  combinational `IMEM` read data for `IMEM_PC`.
- `F_instruction`  out  32  IF/ID instruction; 32'h0 (NOP) when not valid.
- `F_pc_plus4`  out  32  IF/ID PC+4 of the captured instruction.
- `F_valid`  out  1  IF/ID holds a real instruction.
- `F_fetch_count`  out  CNT_W  valid instructions captured; saturating.
- `F_bubble_count`  out  CNT_W  stall or flush edges; saturating.

## Operation
- Priority per falling edge, highest first: `SYS_load`, then `EX_redirect`, then `D_stall`, then normal fetch.
- **Load:**
  - PC <= {24'b0, SYS_pc_val[7:2], 2'b00}.
  - IF/ID is flushed: instruction = 0, pc_plus4 = 0, valid = 0.
  - Bubble counter +1.
- **Redirect:**
  - PC <= {EX_target[31:2], 2'b00}.
  - IF/ID is flushed.
  - Bubble counter +1.
  - `D_stall` is ignored on the same edge.
- **Stall:**
  - PC and all IF/ID fields hold their values.
  - Bubble counter +1; fetch counter unchanged.
- **Normal:**
  - IF/ID <= {IMEM_instruction, PC+4, valid = 1}.
  - PC <= PC + 4.
  - Fetch counter +1.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0, and `F_pc_plus4` wraps the same way.
- Both counters saturate at all-ones and never wrap.
- `SYS_load` held for N edges: the PC stays at the loaded value, IF/ID stays flushed, and the bubble counter advances N.
- The stage reads no decode-stage state. Hazard detection lives outside this block.

## Timing
- Reset, asynchronous on `SYS_reset_n` low:
  - PC = RESET_PC, so `IMEM_PC` = RESET_PC immediately.
  - `F_instruction` = 0, `F_pc_plus4` = 0, `F_valid` = 0.
  - Both counters = 0.
- Reset asserted mid-operation: the same values appear immediately; no edge is needed.
- First edge after reset release with no controls asserted:
  - captures the instruction at RESET_PC with `F_valid` = 1 and `F_pc_plus4` = RESET_PC + 4;
  - PC becomes RESET_PC + 4.
- Latency: an instruction at PC p appears on `F_instruction` one falling edge after `IMEM_PC` = p.
- Redirect penalty:
  - The edge that takes `EX_redirect` leaves a bubble in IF/ID.
  - The next edge captures the instruction at the target.
  - Squashing the instruction already in ID/EX is the EX/hazard logic's job.
- Control inputs are sampled only at the falling edge. Glitches between edges have no effect.

## Structure
- Shared pipeline package holds:
  - `NOP_INSTR` = 32'h0;
  - `PC_INC` = 4;
  - instruction width 32;
  - the IF/ID bundle struct {instruction, pc_plus4, valid}, reused by `decode_stage`.
- One sub-module, `sat_counter` (CNT_W wide, inc enable, saturating), instantiated twice: fetch count and bubble count.
- The PC next-value mux and the IF/ID register stay in `fetch_stage`.

## Test plan
- **Reset then free-run.** Reset, release, IMEM[i] = 32'h1000_0000 + i, 3 edges -> `F_instruction` 32'h1000_0000, 1, 2 in turn; `F_pc_plus4` = 4, 8, 12; PC = 12; `F_fetch_count` = 3.
- **Stall.** `D_stall` for 2 edges while IF/ID holds PC 8's instruction -> IF/ID and PC unchanged; `F_bubble_count` +2; the following edge captures PC 12.
- **Redirect vs stall.** `EX_redirect` = 1, `EX_target` = 32'h0000_0043, `D_stall` = 1 on the same edge -> PC = 32'h40; `F_valid` = 0, `F_instruction` = 0; next edge captures IMEM at 32'h40.
- **Load vs redirect.** `SYS_load` = 1, `SYS_pc_val` = 8'h27, `EX_redirect` = 1 on the same edge -> PC = 32'h24; IF/ID flushed.
- **Wrap and saturation.**
  - Redirect to 32'hFFFF_FFFC, then 2 edges -> `F_pc_plus4` = 0 and PC wraps to 4.
  - CNT_W = 4, 20 normal edges -> `F_fetch_count` = 4'hF.
- **Asynchronous reset mid-stall.** `SYS_reset_n` low between edges -> all outputs at reset values at once, with no clock edge.
